// File: rtl/uio_bus_arbiter_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_e;

  localparam int OWNER_W = 3;
  localparam int BYTE_W  = 8;

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Bundle of requester-side and pad-side signals around the uio arbiter.
interface uio_bus_arbiter_if
  import uio_arb_pkg::*;
#(
  parameter int NREQ = 4
);
  logic                     ena;
  logic [NREQ-1:0]          req;
  logic [NREQ*BYTE_W-1:0]   wdata;
  logic [NREQ*BYTE_W-1:0]   woe;
  logic [BYTE_W-1:0]        uio_in;
  logic [NREQ-1:0]          gnt;
  logic [OWNER_W-1:0]       owner;
  logic                     busy;
  logic [BYTE_W-1:0]        rdata;
  logic [BYTE_W-1:0]        uio_out;
  logic [BYTE_W-1:0]        uio_oe;

  modport master (
    output ena, req, wdata, woe, uio_in,
    input  gnt, owner, busy, rdata, uio_out, uio_oe
  );

  modport slave (
    input  ena, req, wdata, woe, uio_in,
    output gnt, owner, busy, rdata, uio_out, uio_oe
  );
endinterface

// File: rtl/uio_bus_arbiter_rr_picker.sv
// Round-robin pick: first asserted request scanning last_ptr+1, +2, ... modulo NREQ.
module rr_picker
  import uio_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] last_ptr,
  output logic [OWNER_W-1:0] pick,
  output logic               any_req
);

  logic found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (i == (int'(last_ptr) + k) % NREQ)) begin
          pick  = OWNER_W'(i);
          found = 1'b1;
        end
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pad bus with bounded tenure and a pads-released turnaround.
//   state | meaning
//   IDLE  | no owner, pads released, grant on any request while enabled
//   OWN   | owner drives pads, hold counter runs toward the tenure limit
//   TURN  | pads released for TURN_CYC cycles; last cycle arbitrates like IDLE
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input logic           clk,
  input logic           rst,
  uio_bus_arbiter_if.slave bus
);

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam int TURN_W = $clog2(TURN_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);

  arb_state_e          state, state_nxt;
  logic [NREQ-1:0]     gnt, gnt_nxt;
  logic [OWNER_W-1:0]  owner, owner_nxt;
  logic [OWNER_W-1:0]  last_ptr, last_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [TURN_W-1:0]   turn_cnt, turn_nxt;
  logic [BYTE_W-1:0]   rdata;
  logic [OWNER_W-1:0]  pick;
  logic                any_req, grant_now, own_req, other_req;
  logic [BYTE_W-1:0]   own_data, own_oe;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req      (bus.req),
    .last_ptr (last_ptr),
    .pick     (pick),
    .any_req  (any_req)
  );

  // gnt is one-hot of owner while in OWN, so it doubles as the owner mask
  assign own_req   = |(bus.req & gnt);
  assign other_req = |(bus.req & ~gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      owner    <= '0;
      last_ptr <= OWNER_W'(NREQ - 1);
      hold_cnt <= '0;
      turn_cnt <= '0;
      rdata    <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      owner    <= owner_nxt;
      last_ptr <= last_nxt;
      hold_cnt <= hold_nxt;
      turn_cnt <= turn_nxt;
      rdata    <= bus.uio_in;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    last_nxt  = last_ptr;
    hold_nxt  = hold_cnt;
    turn_nxt  = turn_cnt;
    grant_now = 1'b0;
    case (state)
      ST_IDLE: grant_now = bus.ena && any_req;
      ST_OWN: begin
        if (!own_req || !bus.ena || (hold_cnt == HOLD_LAST && other_req)) begin
          state_nxt = ST_TURN;
          gnt_nxt   = '0;
          turn_nxt  = '0;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ST_TURN: begin
        if (turn_cnt == TURN_LAST) begin
          if (bus.ena && any_req) grant_now = 1'b1;
          else                    state_nxt = ST_IDLE;
        end else begin
          turn_nxt = turn_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (grant_now) begin
      state_nxt = ST_OWN;
      gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
      owner_nxt = pick;
      last_nxt  = pick;
      hold_nxt  = '0;
    end
  end

  always_comb begin
    own_data = '0;
    own_oe   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == OWNER_W'(i)) begin
        own_data = bus.wdata[BYTE_W*i +: BYTE_W];
        own_oe   = bus.woe[BYTE_W*i +: BYTE_W];
      end
    end
  end

  assign bus.gnt     = gnt;
  assign bus.owner   = owner;
  assign bus.busy    = (state == ST_OWN);
  assign bus.rdata   = rdata;
  assign bus.uio_out = (state == ST_OWN) ? own_data : '0;
  assign bus.uio_oe  = (state == ST_OWN) ? own_oe   : '0;

endmodule
